mem_port_mux: RTL and testbench
===============================

MEM_PORT_MUX -- requirements
Module: mem_port_mux

Interface
REQ-001 The block SHALL have parameter PORTS_NUM, default 4, meaning the number of requester ports (min 2).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 16, meaning the memory data width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles before abort (used only with the timeout macro).
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 clk  input  1  clock clk, all logic on rising edge.
REQ-007 gnt  input  PORTS_NUM  one-hot grant from the round-robin arbiter.
REQ-008 port_wr  input  PORTS_NUM  per-port access type, 1=write, 0=read.
REQ-009 port_addr  input  PORTS_NUM*ADDR_W  flattened per-port address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 port_wdata  input  PORTS_NUM*DATA_W  flattened per-port write data, same packing.
REQ-011 port_ack  output  PORTS_NUM  one-cycle completion pulse to the served port.
REQ-012 port_err  output  1  qualifies port_ack: transaction aborted.
REQ-013 port_rdata  output  DATA_W  read data, valid while port_ack is high.
REQ-014 mem_req, mem_wr  output  1 each  memory request and access type.
REQ-015 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address and write data.
REQ-016 mem_ack  input  1  memory completion strobe.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 In IDLE with gnt!=0, the block SHALL latch the granted index and that port's wr/addr/wdata, then enter BUSY.
REQ-020 If gnt is multi-hot, the lowest set index SHALL be served.
REQ-021 mem_req SHALL be registered and high exactly while in BUSY; mem_wr/addr/wdata SHALL hold the latched values throughout BUSY.
REQ-022 gnt, port_* and mem_ack changes outside their sampled state SHALL be ignored; mem_ack is sampled only in BUSY.
REQ-023 On mem_ack in BUSY, the block SHALL capture mem_rdata (0 for writes) into port_rdata and enter DONE.
REQ-024 In DONE, port_ack[latched index] SHALL be 1 for exactly one cycle, port_err SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-025 The requester SHALL drop req on the edge ending its ack cycle, so gnt is 0 in the following IDLE cycle and the arbiter rotates.
REQ-026 Latency: gnt in cycle N gives mem_req in N+1; mem_ack in cycle M gives port_ack in M+1; the minimum issue-to-issue interval is 3 cycles.
REQ-027 mem_ack asserted in the first BUSY cycle SHALL complete the transaction (zero-wait memory).
REQ-028 port_rdata SHALL hold its value until the next completion.

Reset
REQ-029 Asserting reset at any time, including mid-BUSY, SHALL force IDLE and set mem_req=0, port_ack=0, port_err=0, port_rdata=0, mem_wr=0, mem_addr=0, mem_wdata=0 and the latched index to 0, with no completion pulse issued for the aborted transaction.

Configuration
REQ-030 With macro MEM_PORT_MUX_TIMEOUT_EN defined, a counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ack; at TIMEOUT_CYCLES, the block SHALL drop mem_req, enter DONE with port_err=1 and port_rdata=0.
REQ-031 mem_ack in the same cycle the limit is reached SHALL take priority, giving a normal completion.
REQ-032 Without MEM_PORT_MUX_TIMEOUT_EN, BUSY SHALL wait indefinitely, no counter SHALL be built, and port_err SHALL be tied to 0.

Verification
REQ-033 gnt=4'b0100, port_wr[2]=0, port_addr[2]=16'h0123, mem_ack one cycle after mem_req with mem_rdata=16'hBEEF -> mem_addr=16'h0123, mem_wr=0, port_ack=4'b0100 for one cycle, port_rdata=16'hBEEF.
REQ-034 gnt=4'b0001 write with wdata 16'hA5A5, mem_ack in the first BUSY cycle -> mem_req high for 1 cycle, mem_wdata=16'hA5A5, port_ack[0] in the next cycle, then IDLE.
REQ-035 gnt=4'b1010 -> port 1 is served; then gnt changes to 4'b1000 during BUSY -> the latched addr and ack target remain port 1.
REQ-036 reset pulsed during BUSY -> mem_req drops immediately, no port_ack; a fresh gnt after reset is served normally.
REQ-037 With MEM_PORT_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ack never asserted -> mem_req drops after 8 BUSY cycles, port_ack pulses with port_err=1 and port_rdata=0.
REQ-038 All four ports request back-to-back with the arbiter attached -> served in order 0,1,2,3, and each port_ack is a single-cycle pulse.

Source files
------------

// File: rtl/mem_port_mux.sv
// mem_port_mux: serves one granted requester port at a time onto a single
// memory port, returning a one-cycle ack plus read data to that port.
//
// Optional build macro: MEM_PORT_MUX_TIMEOUT_EN. When defined, a BUSY-cycle
// counter aborts a transaction after TIMEOUT_CYCLES cycles without mem_ack.
// The abort is reported as port_ack with port_err=1 and port_rdata=0.
//
// Ports
//   clk, reset        : clock (rising edge); asynchronous active-high reset
//   gnt               : one-hot grant from the arbiter. If several bits are set,
//                       the lowest set bit wins.
//   port_wr/addr/wdata: per-port request fields. Port i sits at [i*W +: W].
//   port_ack          : one-cycle completion pulse to the served port
//   port_err          : qualifies port_ack. 1 means the transaction was aborted.
//   port_rdata        : completion read data, held until the next completion
//   mem_req/wr/addr/wdata : registered memory request, held through BUSY
//   mem_ack, mem_rdata: memory completion strobe and read data
module mem_port_mux #(
  parameter int unsigned PORTS_NUM      = 4,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORTS_NUM-1:0]        gnt,
  input  logic [PORTS_NUM-1:0]        port_wr,
  input  logic [PORTS_NUM*ADDR_W-1:0] port_addr,
  input  logic [PORTS_NUM*DATA_W-1:0] port_wdata,
  output logic [PORTS_NUM-1:0]        port_ack,
  output logic                        port_err,
  output logic [DATA_W-1:0]           port_rdata,
  output logic                        mem_req,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IDX_W = $clog2(PORTS_NUM);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PORTS_NUM-1:0]   port_ack_q, port_ack_d;
  logic [DATA_W-1:0]      port_rdata_q, port_rdata_d;

  logic                   sel_any;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_wr;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

`ifdef MEM_PORT_MUX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   port_err_q, port_err_d;
`endif

  // Lowest-index grant select: scan downward so the lowest set bit wins.
  always_comb begin
    sel_any   = |gnt;
    sel_idx   = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = PORTS_NUM - 1; i >= 0; i--) begin
      if (gnt[i]) begin
        sel_idx   = IDX_W'(i);
        sel_wr    = port_wr[i];
        sel_addr  = port_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = port_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and registered outputs.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    idx_d        = idx_q;
    port_ack_d   = '0;
    port_rdata_d = port_rdata_q;
`ifdef MEM_PORT_MUX_TIMEOUT_EN
    cnt_d        = cnt_q;
    port_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_wr_d    = sel_wr;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          idx_d       = sel_idx;
`ifdef MEM_PORT_MUX_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        // mem_ack wins over a timeout that expires in the same cycle.
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          port_ack_d   = PORTS_NUM'(1) << idx_q;
          port_rdata_d = mem_wr_q ? '0 : mem_rdata;
        end
`ifdef MEM_PORT_MUX_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          port_ack_d   = PORTS_NUM'(1) << idx_q;
          port_rdata_d = '0;
          port_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      idx_q        <= '0;
      port_ack_q   <= '0;
      port_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      idx_q        <= idx_d;
      port_ack_q   <= port_ack_d;
      port_rdata_q <= port_rdata_d;
    end
  end

`ifdef MEM_PORT_MUX_TIMEOUT_EN
  // BUSY-cycle watchdog counter and abort flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      port_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      port_err_q <= port_err_d;
    end
  end
  assign port_err = port_err_q;
`else
  assign port_err = 1'b0;
`endif

  assign port_ack   = port_ack_q;
  assign port_rdata = port_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_mux.sv
// Directed bench for mem_port_mux (4 ports, 16-bit address/data, TIMEOUT_CYCLES=8).
// When MEM_PORT_MUX_TIMEOUT_EN is defined, the abort path is also exercised.
module tb_mem_port_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  gnt_t, gnt_arb, gnt_w;
  logic [3:0]  port_wr;
  logic [63:0] port_addr;
  logic [63:0] port_wdata;
  logic [3:0]  port_ack;
  logic        port_err;
  logic [15:0] port_rdata;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack_t, mem_ack_w;
  logic [15:0] mem_rdata;

  logic        arb_mode, arb_load;
  logic [3:0]  arb_req;
  int          arb_ptr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // In arbiter mode, use a round-robin arbiter and a zero-wait memory.
  assign gnt_w     = arb_mode ? gnt_arb : gnt_t;
  assign mem_ack_w = arb_mode ? mem_req : mem_ack_t;

  always_comb begin
    gnt_arb = '0;
    for (int k = 3; k >= 0; k--)
      if (arb_req[(arb_ptr + k) % 4]) gnt_arb = 4'(1) << ((arb_ptr + k) % 4);
  end

  always_ff @(posedge clk) begin
    if (arb_load) begin
      arb_req <= 4'hF;
      arb_ptr <= 0;
    end else if (port_ack != 4'h0) begin
      arb_req <= arb_req & ~port_ack;
      for (int k = 0; k < 4; k++)
        if (port_ack[k]) arb_ptr <= (k + 1) % 4;
    end
  end

  mem_port_mux #(
    .PORTS_NUM(4), .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .gnt(gnt_w), .port_wr(port_wr),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_ack(port_ack),
    .port_err(port_err), .port_rdata(port_rdata), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack_w), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         seen;
    logic [3:0] prev_ack;

    reset = 1'b1; gnt_t = '0; port_wr = '0; port_addr = '0; port_wdata = '0;
    mem_ack_t = 1'b0; mem_rdata = '0; arb_mode = 1'b0; arb_load = 1'b0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_port_ack", 32'(port_ack), 32'h0);
    chk("rst_port_rdata", 32'(port_rdata), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;

    // Read from port 2 with a single memory wait cycle.
    port_addr[2*16 +: 16] = 16'h0123; port_wr[2] = 1'b0; gnt_t = 4'b0100;
    tick();
    chk("rd_mem_req", 32'(mem_req), 32'h1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0123);
    chk("rd_mem_wr", 32'(mem_wr), 32'h0);
    tick();
    chk("rd_wait_req", 32'(mem_req), 32'h1);
    chk("rd_wait_ack", 32'(port_ack), 32'h0);
    mem_ack_t = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    chk("rd_port_ack", 32'(port_ack), 32'h4);
    chk("rd_port_rdata", 32'(port_rdata), 32'hBEEF);
    chk("rd_port_err", 32'(port_err), 32'h0);
    chk("rd_req_drop", 32'(mem_req), 32'h0);
    mem_ack_t = 1'b0; gnt_t = '0;
    tick();
    chk("rd_ack_pulse", 32'(port_ack), 32'h0);
    chk("rd_rdata_hold", 32'(port_rdata), 32'hBEEF);

    // Write from port 0 with a zero-wait memory. mem_rdata must not reach port_rdata.
    port_wr[0] = 1'b1; port_wdata[0 +: 16] = 16'hA5A5; port_addr[0 +: 16] = 16'h0010;
    gnt_t = 4'b0001;
    tick();
    chk("wr_mem_req", 32'(mem_req), 32'h1);
    chk("wr_mem_wr", 32'(mem_wr), 32'h1);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5A5);
    mem_ack_t = 1'b1; mem_rdata = 16'h1234; gnt_t = '0;
    tick();
    chk("wr_port_ack", 32'(port_ack), 32'h1);
    chk("wr_req_1cyc", 32'(mem_req), 32'h0);
    chk("wr_rdata_zero", 32'(port_rdata), 32'h0);
    mem_ack_t = 1'b0;
    tick();
    chk("wr_idle_ack", 32'(port_ack), 32'h0);
    // A stray mem_ack in IDLE must be ignored.
    mem_ack_t = 1'b1;
    tick();
    chk("stray_ack_req", 32'(mem_req), 32'h0);
    chk("stray_ack_pack", 32'(port_ack), 32'h0);
    mem_ack_t = 1'b0;

    // Multi-hot grant: the lowest set bit (port 1) is served, and a grant change mid-BUSY is ignored.
    port_addr[1*16 +: 16] = 16'h1111; port_addr[3*16 +: 16] = 16'h3333;
    port_wr[1] = 1'b0; gnt_t = 4'b1010;
    tick();
    chk("mh_mem_addr", 32'(mem_addr), 32'h1111);
    gnt_t = 4'b1000;
    tick();
    chk("mh_addr_hold", 32'(mem_addr), 32'h1111);
    mem_ack_t = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    chk("mh_port_ack", 32'(port_ack), 32'h2);
    chk("mh_rdata", 32'(port_rdata), 32'h5A5A);
    mem_ack_t = 1'b0; gnt_t = '0;
    tick();

    // Reset asserted during BUSY.
    gnt_t = 4'b0001;
    tick();
    chk("rb_mem_req", 32'(mem_req), 32'h1);
    gnt_t = '0; reset = 1'b1;
    #1;
    chk("rb_req_async", 32'(mem_req), 32'h0);
    chk("rb_addr_clr", 32'(mem_addr), 32'h0);
    chk("rb_rdata_clr", 32'(port_rdata), 32'h0);
    tick();
    reset = 1'b0; mem_ack_t = 1'b1;
    tick();
    chk("rb_no_ack", 32'(port_ack), 32'h0);
    mem_ack_t = 1'b0;
    gnt_t = 4'b0100;
    tick();
    chk("rb_fresh_addr", 32'(mem_addr), 32'h0123);
    mem_ack_t = 1'b1; mem_rdata = 16'hBEEF; gnt_t = '0;
    tick();
    chk("rb_fresh_ack", 32'(port_ack), 32'h4);
    mem_ack_t = 1'b0;
    tick();

    // Memory never answers. This either times out or waits indefinitely.
    gnt_t = 4'b0010;
    tick();
    gnt_t = '0;
`ifdef MEM_PORT_MUX_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_busy%0d", i), 32'({mem_req, port_ack}), 32'h10);
      tick();
    end
    chk("to_req_drop", 32'(mem_req), 32'h0);
    chk("to_port_ack", 32'(port_ack), 32'h2);
    chk("to_port_err", 32'(port_err), 32'h1);
    chk("to_rdata_zero", 32'(port_rdata), 32'h0);
    tick();
    chk("to_err_pulse", 32'(port_err), 32'h0);
    // mem_ack in the limit cycle gives a normal completion.
    gnt_t = 4'b0010;
    tick();
    gnt_t = '0;
    for (int i = 0; i < 7; i++) tick();
    mem_ack_t = 1'b1; mem_rdata = 16'h7777;
    tick();
    chk("to_prio_ack", 32'(port_ack), 32'h2);
    chk("to_prio_err", 32'(port_err), 32'h0);
    chk("to_prio_rdata", 32'(port_rdata), 32'h7777);
    mem_ack_t = 1'b0;
    tick();
`else
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("wait%0d", i), 32'({mem_req, port_err, port_ack}), 32'h20);
      tick();
    end
    mem_ack_t = 1'b1; mem_rdata = 16'h7777;
    tick();
    chk("wait_ack", 32'(port_ack), 32'h2);
    chk("wait_err", 32'(port_err), 32'h0);
    chk("wait_rdata", 32'(port_rdata), 32'h7777);
    mem_ack_t = 1'b0;
    tick();
`endif

    // All four ports request back-to-back through the arbiter.
    for (int i = 0; i < 4; i++) port_addr[i*16 +: 16] = 16'(16'h0100 * i);
    port_wr = '0; mem_rdata = 16'hC0DE;
    arb_load = 1'b1;
    tick();
    arb_load = 1'b0; arb_mode = 1'b1;
    seen = 0; prev_ack = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (port_ack != 4'h0) begin
        chk($sformatf("arb_order%0d", seen), 32'(port_ack), 32'(4'(1) << (seen % 4)));
        chk($sformatf("arb_pulse%0d", seen), 32'(prev_ack), 32'h0);
        seen++;
      end
      prev_ack = port_ack;
    end
    chk("arb_count", 32'(seen), 32'd4);
    arb_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
